// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: command, operand, ALU and result signals of the ALU op sequencer.
//   cmd_*      : opcode command handshake (cmd_valid/cmd_ready, cmd_op, cmd_use_carry), clr_carry
//   data_*     : operand byte stream handshake (data_valid/data_ready, data_in)
//   alu_*      : ALU drive (alu_a, alu_b, alu_op, alu_cin, alu_start) and return (alu_result, alu_cout)
//   res_*      : result handshake (res_valid/res_ready) with data_out, carry_out; busy status
interface alu_op_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 8
);
    logic              cmd_valid, cmd_ready, cmd_use_carry, clr_carry;
    logic [OP_W-1:0]   cmd_op, alu_op;
    logic              data_valid, data_ready;
    logic [DATA_W-1:0] data_in, alu_a, alu_b, alu_result, data_out;
    logic              alu_cin, alu_start, alu_cout;
    logic              res_valid, res_ready, carry_out, busy;

    modport master (
        output cmd_valid, cmd_op, cmd_use_carry, clr_carry, data_valid, data_in,
               alu_result, alu_cout, res_ready,
        input  cmd_ready, data_ready, alu_a, alu_b, alu_op, alu_cin, alu_start,
               res_valid, data_out, carry_out, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_use_carry, clr_carry, data_valid, data_in,
               alu_result, alu_cout, res_ready,
        output cmd_ready, data_ready, alu_a, alu_b, alu_op, alu_cin, alu_start,
               res_valid, data_out, carry_out, busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: sequences one ALU operation (command, operand A, operand B, issue, wait, result).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, aborts any operation in flight
//   bus   : slave side of alu_op_sequencer_if (command, operand, ALU and result ports)
module alu_op_sequencer #(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 8,
    parameter int ALU_LAT = 1
) (
    input logic               clk,
    input logic               rst_n,
    alu_op_sequencer_if.slave bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] GET_A = 3'd1;
    localparam logic [2:0] GET_B = 3'd2;
    localparam logic [2:0] EXEC  = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
    localparam logic [2:0] OUT   = 3'd5;

    logic [2:0]        state;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic [OP_W-1:0]   op_q;
    logic              uc_q, carry_q, capture;

    // ALU result is sampled at the end of EXEC for a single-cycle ALU, else at the last WAIT cycle
    assign capture = (state == EXEC && ALU_LAT == 1) || (state == WAIT && cnt == 4'd0);

    // handshake strobes are gated by rst_n so they drop the moment reset asserts
    always_comb begin
        bus.cmd_ready  = rst_n && state == IDLE;
        bus.data_ready = rst_n && (state == GET_A || state == GET_B);
        bus.alu_start  = rst_n && state == EXEC;
        bus.res_valid  = rst_n && state == OUT;
        bus.busy       = rst_n && state != IDLE;
        bus.alu_a      = a_q;
        bus.alu_b      = b_q;
        bus.alu_op     = op_q;
        bus.alu_cin    = uc_q && carry_q;
        bus.data_out   = res_q;
        bus.carry_out  = carry_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            uc_q    <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            case (state)
                IDLE:  if (bus.cmd_valid) begin
                           op_q  <= bus.cmd_op;
                           uc_q  <= bus.cmd_use_carry;
                           state <= GET_A;
                       end
                GET_A: if (bus.data_valid) begin
                           a_q   <= bus.data_in;
                           state <= GET_B;
                       end
                GET_B: if (bus.data_valid) begin
                           b_q   <= bus.data_in;
                           state <= EXEC;
                       end
                EXEC:  begin
                           cnt   <= 4'(ALU_LAT - 2);
                           state <= ALU_LAT == 1 ? OUT : WAIT;
                       end
                WAIT:  begin
                           cnt <= cnt - 4'd1;
                           if (cnt == 4'd0) state <= OUT;
                       end
                OUT:   if (bus.res_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
            // a capture in the same cycle as clr_carry takes priority
            if (capture) begin
                res_q   <= bus.alu_result;
                carry_q <= bus.alu_cout;
            end else if (bus.clr_carry) begin
                carry_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench for ALU_LAT=1 (adder) and ALU_LAT=3 (pipelined adder) instances.
module tb_alu_op_sequencer;
    typedef struct packed {
        logic       c;
        logic [7:0] d;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel = 1'b0;
    logic       cmd_valid = 1'b0, cmd_use_carry = 1'b0, clr_carry = 1'b0;
    logic       data_valid = 1'b0, res_ready = 1'b0;
    logic [7:0] cmd_op = 8'h00, data_in = 8'h00;
    logic       exp_carry [2];
    res_t       sb[$];
    int         cmp_cnt = 0, err_cnt = 0;

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.DATA_W(8), .OP_W(8)) i1 ();
    alu_op_sequencer_if #(.DATA_W(8), .OP_W(8)) i3 ();

    alu_op_sequencer #(.DATA_W(8), .OP_W(8), .ALU_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));
    alu_op_sequencer #(.DATA_W(8), .OP_W(8), .ALU_LAT(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(i3.slave));

    assign i1.cmd_valid     = cmd_valid & ~sel;
    assign i1.cmd_op        = cmd_op;
    assign i1.cmd_use_carry = cmd_use_carry;
    assign i1.clr_carry     = clr_carry & ~sel;
    assign i1.data_valid    = data_valid & ~sel;
    assign i1.data_in       = data_in;
    assign i1.res_ready     = res_ready & ~sel;
    assign i3.cmd_valid     = cmd_valid & sel;
    assign i3.cmd_op        = cmd_op;
    assign i3.cmd_use_carry = cmd_use_carry;
    assign i3.clr_carry     = clr_carry & sel;
    assign i3.data_valid    = data_valid & sel;
    assign i3.data_in       = data_in;
    assign i3.res_ready     = res_ready & sel;

    // single-cycle combinational adder
    logic [8:0] s1;
    assign s1 = i1.alu_a + i1.alu_b + i1.alu_cin;
    assign i1.alu_result = s1[7:0];
    assign i1.alu_cout   = s1[8];

    // 3-cycle adder: valid only two cycles after the start pulse, junk otherwise
    logic [1:0] p3;
    logic [8:0] s3;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) p3 <= 2'b00;
        else        p3 <= {p3[0], i3.alu_start};
    assign s3 = i3.alu_a + i3.alu_b + i3.alu_cin;
    assign i3.alu_result = p3[1] ? s3[7:0] : 8'hA5;
    assign i3.alu_cout   = p3[1] & s3[8];

    logic       m_cmd_ready, m_data_ready, m_alu_start, m_alu_cin, m_res_valid, m_carry_out, m_busy;
    logic [7:0] m_alu_a, m_alu_b, m_alu_op, m_data_out;
    assign m_cmd_ready  = sel ? i3.cmd_ready  : i1.cmd_ready;
    assign m_data_ready = sel ? i3.data_ready : i1.data_ready;
    assign m_alu_start  = sel ? i3.alu_start  : i1.alu_start;
    assign m_alu_cin    = sel ? i3.alu_cin    : i1.alu_cin;
    assign m_res_valid  = sel ? i3.res_valid  : i1.res_valid;
    assign m_carry_out  = sel ? i3.carry_out  : i1.carry_out;
    assign m_busy       = sel ? i3.busy       : i1.busy;
    assign m_alu_a      = sel ? i3.alu_a      : i1.alu_a;
    assign m_alu_b      = sel ? i3.alu_b      : i1.alu_b;
    assign m_alu_op     = sel ? i3.alu_op     : i1.alu_op;
    assign m_data_out   = sel ? i3.data_out   : i1.data_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // one command, cycle 0 = command handshake; rv = first res_valid cycle minus gap
    task automatic run_op(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic uc, input int gap, input int hold, input int lat,
                          input logic clr_cap, input logic next_cmd, output int rv);
        logic       cin;
        logic [8:0] s;
        logic [7:0] d0;
        res_t       e;
        int         c, k;
        cin = uc & exp_carry[sel];
        s = a + b + cin;
        check("cmd_ready_idle", m_cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_use_carry = uc;
        @(negedge clk); cmd_valid = 1'b0; c = 1;
        check("busy_run", m_busy, 1);
        for (int i = 0; i < gap; i++) begin
            check("stall_ready", m_data_ready, 1);
            @(negedge clk); c++;
        end
        check("start_lo_a", m_alu_start, 0);
        data_valid = 1'b1; data_in = a;
        @(negedge clk); c++;
        check("start_lo_b", m_alu_start, 0);
        data_in = b;
        sb.push_back(res_t'(s));
        @(negedge clk); c++; data_valid = 1'b0;
        check("alu_start", m_alu_start, 1);
        check("alu_cin", m_alu_cin, cin);
        check("alu_op", m_alu_op, op);
        check("alu_a", m_alu_a, a);
        check("alu_b", m_alu_b, b);
        k = 0;
        while (!m_res_valid && k < 40) begin
            clr_carry = clr_cap && (c == gap + 2 + lat);
            @(negedge clk); c++; k++;
            clr_carry = 1'b0;
            check("start_pulse", m_alu_start, 0);
            if (!m_res_valid) begin
                check("hold_a", m_alu_a, a);
                check("hold_b", m_alu_b, b);
                check("hold_op", m_alu_op, op);
            end
        end
        check("res_timeout", m_res_valid, 1);
        rv = c - gap;
        d0 = m_data_out;
        cmd_valid = next_cmd; cmd_op = 8'hEE;
        for (int i = 0; i < hold; i++) begin
            check("bp_valid", m_res_valid, 1);
            check("bp_data", m_data_out, d0);
            check("bp_cmd_ready", m_cmd_ready, 0);
            @(negedge clk);
        end
        check("hs_cmd_ready", m_cmd_ready, 0);
        check("hs_op", m_alu_op, op);
        check("sb_size", sb.size(), 1);
        e = sb.pop_front();
        check("data_out", m_data_out, e.d);
        check("carry_out", m_carry_out, e.c);
        exp_carry[sel] = e.c;
        res_ready = 1'b1;
        @(negedge clk); res_ready = 1'b0;
        check("post_cmd_ready", m_cmd_ready, 1);
        check("post_busy", m_busy, 0);
        check("post_res_valid", m_res_valid, 0);
        check("data_keep", m_data_out, e.d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  rv;
        logic any_rv;
        exp_carry[0] = 1'b0; exp_carry[1] = 1'b0;
        #13;
        check("rst_cmd_ready", m_cmd_ready, 0);
        check("rst_data_ready", m_data_ready, 0);
        check("rst_alu_start", m_alu_start, 0);
        check("rst_res_valid", m_res_valid, 0);
        check("rst_busy", m_busy, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("rel_cmd_ready", m_cmd_ready, 1);
        check("rel_busy", m_busy, 0);
        check("rel_res_valid", m_res_valid, 0);
        check("rel_carry", m_carry_out, 0);

        run_op(8'h01, 8'h12, 8'h34, 1'b0, 0, 0, 1, 1'b0, 1'b0, rv);
        check("lat1_cycle", rv, 4);
        run_op(8'h01, 8'hFF, 8'h01, 1'b0, 0, 0, 1, 1'b0, 1'b0, rv);
        run_op(8'h01, 8'h00, 8'h00, 1'b1, 0, 0, 1, 1'b0, 1'b0, rv);
        run_op(8'h01, 8'hFF, 8'h01, 1'b0, 0, 0, 1, 1'b0, 1'b0, rv);
        clr_carry = 1'b1;
        @(negedge clk); clr_carry = 1'b0; exp_carry[0] = 1'b0;
        check("clr_idle", m_carry_out, 0);
        run_op(8'h01, 8'h00, 8'h00, 1'b1, 0, 0, 1, 1'b0, 1'b0, rv);
        run_op(8'h02, 8'h55, 8'h0A, 1'b0, 3, 5, 1, 1'b0, 1'b1, rv);
        check("gap_cycle", rv, 4);
        run_op(8'h03, 8'h80, 8'h80, 1'b0, 0, 0, 1, 1'b0, 1'b0, rv);
        check("held_cmd_cycle", rv, 4);

        sel = 1'b1;
        @(negedge clk);
        run_op(8'h01, 8'h10, 8'h20, 1'b0, 0, 0, 3, 1'b0, 1'b0, rv);
        check("lat3_cycle", rv, 6);
        run_op(8'h01, 8'hFF, 8'h01, 1'b0, 0, 2, 3, 1'b1, 1'b0, rv);
        check("cap_over_clr", m_carry_out, 1);

        cmd_valid = 1'b1; cmd_op = 8'h01; cmd_use_carry = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        data_valid = 1'b1; data_in = 8'h11;
        @(negedge clk); data_in = 8'h22;
        @(negedge clk); data_valid = 1'b0;
        @(negedge clk);
        check("wait_busy", m_busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", m_busy, 0);
        check("arst_res_valid", m_res_valid, 0);
        check("arst_cmd_ready", m_cmd_ready, 0);
        check("arst_data_ready", m_data_ready, 0);
        check("arst_alu_start", m_alu_start, 0);
        check("arst_carry", m_carry_out, 0);
        check("arst_alu_a", m_alu_a, 0);
        check("arst_data_out", m_data_out, 0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        exp_carry[0] = 1'b0; exp_carry[1] = 1'b0;
        any_rv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            any_rv |= m_res_valid;
        end
        check("abort_no_valid", any_rv, 0);
        check("abort_idle", m_cmd_ready, 1);
        check("abort_busy", m_busy, 0);
        check("abort_carry", m_carry_out, 0);
        run_op(8'h01, 8'h01, 8'h02, 1'b1, 0, 0, 3, 1'b0, 1'b0, rv);
        check("lat3_after_rst", rv, 6);
        sel = 1'b0;
        @(negedge clk);
        run_op(8'h01, 8'h01, 8'h02, 1'b1, 0, 0, 1, 1'b0, 1'b0, rv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Controller that sequences the 8-bit ALU datapath through one operation.
- Accepts an opcode command, collects operand A then operand B from a shared byte stream, and drives the ALU inputs for a fixed latency.
- Captures the result and carry-out, then presents them on a valid/ready result port.
- Holds a carry flag so multi-byte operations can chain carry between commands. Sits between the CPU front end and the combinational or pipelined ALU.

Parameters:
- DATA_W, 8: operand/result width.
- OP_W, 8: opcode width.
- ALU_LAT, 1: cycles from ALU issue to valid ALU result; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_op  in  OP_W  opcode for this command
- cmd_use_carry  in  1  use stored carry flag as ALU carry-in
- clr_carry  in  1  synchronous clear of carry flag
- data_valid  in  1  operand byte offered
- data_ready  out  1  operand byte accepted when both high
- data_in  in  DATA_W  operand byte
- alu_a  out  DATA_W  ALU operand A
- alu_b  out  DATA_W  ALU operand B
- alu_op  out  OP_W  ALU opcode
- alu_cin  out  1  ALU carry-in
- alu_start  out  1  one-cycle issue pulse
- alu_result  in  DATA_W  ALU result
- alu_cout  in  1  ALU carry-out
- res_valid  out  1  result available
- res_ready  in  1  result consumed when both high
- data_out  out  DATA_W  captured result
- carry_out  out  1  captured carry-out (equals carry flag)
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all data, opcode and flag registers 0; carry flag 0; wait counter 0. While rst_n is low, cmd_ready, data_ready, alu_start, res_valid and busy are all 0.
- Reset mid-operation aborts the operation. No res_valid is produced and the carry flag is cleared.
- States: IDLE, GET_A, GET_B, EXEC, WAIT, OUT.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_op and cmd_use_carry, then go to GET_A.
- GET_A: data_ready=1. On data_valid, latch A, then go to GET_B. Without data_valid, stay in GET_A (stall, no timeout).
- GET_B: data_ready=1. On data_valid, latch B, then go to EXEC.
- EXEC: alu_start=1 for exactly this one cycle.
  - If ALU_LAT=1: capture alu_result/alu_cout at the end of EXEC, then go to OUT.
  - Otherwise: load counter with ALU_LAT-2 and go to WAIT.
- WAIT: decrement counter each cycle. At the end of the cycle where counter==0, capture result/cout and go to OUT.
- OUT: res_valid=1, with data_out and carry_out stable. On res_ready, go to IDLE. cmd_ready is not asserted in the handshake cycle.
- ALU drive:
  - alu_a, alu_b, alu_op are the latched registers; they hold from EXEC through capture and stay held until the next latch.
  - alu_cin = cmd_use_carry_latched ? carry_flag : 0.
  - The opcode passes through unmodified.
- Latency with no stalls: cmd handshake in cycle 0; A in cycle 1; B in cycle 2; EXEC in cycle 3; res_valid first high in cycle 3+ALU_LAT.
- Carry flag:
  - Loaded with alu_cout at capture.
  - clr_carry clears it in any other cycle.
  - If capture and clr_carry occur in the same cycle, capture wins.
- Ignored inputs:
  - data_valid outside GET_A/GET_B (data_ready=0).
  - cmd_valid outside IDLE.
  - res_ready outside OUT.
- data_out holds its last captured value after the result handshake until the next capture.

Test Plan:
- Reset: pulse rst_n low mid-clock.
  - While low: all outputs 0 asynchronously.
  - First cycle after release: cmd_ready=1, busy=0, res_valid=0, carry_out=0.
- ALU_LAT=1, adder model: cmd_op=0x01, A=0x12, B=0x34 back-to-back.
  - alu_start high only in cycle 3, alu_cin=0.
  - res_valid in cycle 4 with data_out=0x46, carry_out=0.
- Carry chain: add 0xFF+0x01 gives data_out=0x00, carry_out=1.
  - Next cmd with cmd_use_carry=1, A=0x00, B=0x00: alu_cin=1, data_out=0x01, carry_out=0.
  - Repeating with clr_carry pulsed in IDLE beforehand gives alu_cin=0.
- Backpressure/stall: hold res_ready low 5 cycles.
  - res_valid stays 1 and data_out stays stable throughout; cmd_ready=0.
  - A cmd_valid held high is accepted only in the cycle after the result handshake.
  - A 3-cycle data_valid gap in GET_A delays res_valid by exactly 3 cycles.
- ALU_LAT=3, pipelined ALU model:
  - res_valid first high in cycle 6.
  - alu_a/alu_b/alu_op unchanged from cycle 3 through cycle 5.
  - clr_carry asserted in the capture cycle (cycle 5) is overridden by alu_cout=1: carry_out=1.
- Reset mid-WAIT (ALU_LAT=3): assert rst_n low in cycle 4.
  - No res_valid ever appears; carry flag 0; state IDLE after release.
  - A subsequent clean command completes normally.
